// File: rtl/pfb_chan_select_if.sv
// Stream bundle for pfb_chan_select: the input stream from the channelizer
// and the output stream towards the AXI wrapper.
//   s_axis_*  : input samples (one FFT bin per beat), tlast ends the frame
//   m_axis_*  : selected samples, tuser = bin index, tlast ends the packet
// Modports: slave = the channel selector, master = the environment around it.
interface pfb_chan_select_if #(
    parameter int DATA_W = 32,
    parameter int USER_W = 10
);
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tlast;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic [USER_W-1:0] m_axis_tuser;
    logic              m_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready;

    modport slave (
        input  s_axis_tdata, s_axis_tlast, s_axis_tvalid,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid,
        input  m_axis_tready
    );

    modport master (
        output s_axis_tdata, s_axis_tlast, s_axis_tvalid,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid,
        output m_axis_tready
    );
endinterface

// File: rtl/pfb_chan_select.sv
// pfb_chan_select: PFB channelizer output stage. Drops FFT bins that are
// disabled in a double-buffered channel mask, tags each kept beat with its
// bin index and groups pkt_frames FFT frames into one output packet.
//
// Ports:
//   ce_clk, ce_rst_n        clock, asynchronous active-low reset
//   set_stb/addr/data       settings bus (mask index/data/commit, frames/packet)
//   fft_size                bins per frame, sampled at each frame start
//   axis (slave modport)    s_axis_* input stream, m_axis_* output stream
//   frame_err_cnt           misaligned-frame counter
//
// Build option: define PFB_CHAN_SEL_ERR_CNT_EN to build the saturating
// frame error counter; otherwise frame_err_cnt is tied to zero.
module pfb_chan_select #(
    parameter int          DATA_W         = 32,
    parameter int          LOG2_MAX_FFT   = 10,
    parameter logic [7:0]  SR_MASK_IDX    = 8'd132,
    parameter logic [7:0]  SR_MASK_DATA   = 8'd133,
    parameter logic [7:0]  SR_MASK_COMMIT = 8'd134,
    parameter logic [7:0]  SR_PKT_FRAMES  = 8'd135
) (
    input  logic                  ce_clk,
    input  logic                  ce_rst_n,
    input  logic                  set_stb,
    input  logic [7:0]            set_addr,
    input  logic [31:0]           set_data,
    input  logic [LOG2_MAX_FFT:0] fft_size,
    pfb_chan_select_if.slave      axis,
    output logic [15:0]           frame_err_cnt
);
    localparam int MAX_FFT = 2**LOG2_MAX_FFT;
    localparam int BIN_W   = LOG2_MAX_FFT;
    localparam int IDX_W   = LOG2_MAX_FFT - 5;

    logic [MAX_FFT-1:0] shadow_mask, active_mask, use_mask;
    logic [IDX_W-1:0]   mask_idx;
    logic               commit_pend, commit_now;
    logic [7:0]         pkt_frames, frame_cnt;
    logic [BIN_W-1:0]   bin_cnt;
    logic [BIN_W:0]     cur_size, size_now;
    logic               rdy_en;

    logic               h_valid, h_fin, h_last;
    logic [DATA_W-1:0]  h_data;
    logic [BIN_W-1:0]   h_bin;
    logic               o_valid, o_last;
    logic [DATA_W-1:0]  o_data;
    logic [BIN_W-1:0]   o_bin;

    logic wr_idx, wr_data, wr_commit, wr_pkt;
    logic frame_start, at_last, bin_en, o_free, s_ready, acc;
    logic frame_end, last_frame, h_to_o;

    assign wr_idx    = set_stb && (set_addr == SR_MASK_IDX);
    assign wr_data   = set_stb && (set_addr == SR_MASK_DATA);
    assign wr_commit = set_stb && (set_addr == SR_MASK_COMMIT);
    assign wr_pkt    = set_stb && (set_addr == SR_PKT_FRAMES);

    always_comb begin
        frame_start = (bin_cnt == '0);
        // The first beat of a frame already uses the new size and, if a
        // commit is pending, the new mask.
        size_now    = frame_start ? fft_size : cur_size;
        at_last     = (({1'b0, bin_cnt} + (BIN_W+1)'(1)) == size_now);
        commit_now  = commit_pend | wr_commit;
        use_mask    = (frame_start && commit_now) ? shadow_mask : active_mask;
        bin_en      = use_mask[bin_cnt];
        o_free      = ~o_valid | axis.m_axis_tready;
        s_ready     = rdy_en & o_free & ~h_fin;
        acc         = axis.s_axis_tvalid & s_ready;
        // A missing tlast at the last bin still closes the frame.
        frame_end   = acc & (axis.s_axis_tlast | at_last);
        last_frame  = (({1'b0, frame_cnt} + 9'd1) >= {1'b0, pkt_frames});
        // H is pushed out by a newer enabled beat, or flushed once it holds
        // the end of a frame.
        h_to_o      = h_valid & ((acc & bin_en) | (h_fin & o_free));
    end

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            shadow_mask <= '1;
            active_mask <= '1;
            mask_idx    <= '0;
            commit_pend <= 1'b0;
            pkt_frames  <= 8'd1;
            frame_cnt   <= '0;
            bin_cnt     <= '0;
            cur_size    <= '0;
            rdy_en      <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (wr_idx) begin
                mask_idx <= set_data[IDX_W-1:0];
            end else if (wr_data) begin
                shadow_mask[{mask_idx, 5'd0} +: 32] <= set_data;
                mask_idx <= mask_idx + IDX_W'(1);
            end
            if (acc && frame_start && commit_now) begin
                active_mask <= shadow_mask;
                commit_pend <= 1'b0;
            end else if (wr_commit) begin
                commit_pend <= 1'b1;
            end
            if (wr_pkt)
                pkt_frames <= (set_data[7:0] == 8'd0) ? 8'd1 : set_data[7:0];
            if (acc && frame_start)
                cur_size <= fft_size;
            if (acc)
                bin_cnt <= frame_end ? '0 : bin_cnt + BIN_W'(1);
            if (frame_end)
                frame_cnt <= last_frame ? 8'd0 : frame_cnt + 8'd1;
        end
    end

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            h_valid <= 1'b0;
            h_fin   <= 1'b0;
            h_last  <= 1'b0;
            h_data  <= '0;
            h_bin   <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_data  <= '0;
            o_bin   <= '0;
        end else begin
            if (h_to_o) begin
                o_valid <= 1'b1;
                o_last  <= h_last;
                o_data  <= h_data;
                o_bin   <= h_bin;
            end else if (axis.m_axis_tready) begin
                o_valid <= 1'b0;
            end

            if (acc && bin_en) begin
                h_valid <= 1'b1;
                h_data  <= axis.s_axis_tdata;
                h_bin   <= bin_cnt;
                h_fin   <= frame_end;
                h_last  <= frame_end & last_frame;
            end else if (frame_end && h_valid) begin
                // Disabled frame-end beat: close the frame on the held beat.
                h_fin   <= 1'b1;
                h_last  <= last_frame;
            end else if (h_to_o) begin
                h_valid <= 1'b0;
                h_fin   <= 1'b0;
                h_last  <= 1'b0;
            end
        end
    end

`ifdef PFB_CHAN_SEL_ERR_CNT_EN
    logic        frame_err;
    logic [15:0] err_cnt;

    // Error: tlast away from the last bin, or the last bin without tlast.
    assign frame_err = acc & (axis.s_axis_tlast ^ at_last);

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n)
            err_cnt <= '0;
        else if (frame_err && (err_cnt != 16'hFFFF))
            err_cnt <= err_cnt + 16'd1;
    end

    assign frame_err_cnt = err_cnt;
`else
    assign frame_err_cnt = '0;
`endif

    assign axis.s_axis_tready = s_ready;
    assign axis.m_axis_tvalid = o_valid;
    assign axis.m_axis_tdata  = o_data;
    assign axis.m_axis_tuser  = o_bin;
    assign axis.m_axis_tlast  = o_last;
endmodule
